// File: rtl/r30_stream_reader_pkg.sv
// Shared definitions for the Rule 30 stream reader: FSM states and default sizing.
package r30_stream_reader_pkg;

  localparam int R30_N_DEF   = 128;
  localparam int R30_W_DEF   = 32;
  localparam int R30_TAP_DEF = R30_N_DEF / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } r30_fsm_e;

endpackage

// File: rtl/r30_stream_reader_ring.sv
// Combinational Rule 30 ring: one generation step over an N-cell circular state.
module r30_stream_reader_ring
  import r30_stream_reader_pkg::*;
#(
  parameter int N = R30_N_DEF
) (
  input  logic [N-1:0] state_in,
  output logic [N-1:0] state_out
);

  // Each cell looks at its left neighbour, itself and its right neighbour, wrapping at the ends.
  for (genvar i = 0; i < N; i++) begin : g_cell
    localparam int LEFT  = (i + N - 1) % N;
    localparam int RIGHT = (i + 1) % N;
    assign state_out[i] = state_in[LEFT] ^ (state_in[i] | state_in[RIGHT]);
  end

endmodule

// File: rtl/r30_stream_reader.sv
// Rule 30 stream reader: steps a seeded ring and packs the tap bit of each
// generation into W-bit words delivered over a valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | no seed loaded, ring frozen, nothing presented
// FILL    | ring stepping once per cycle, collecting tap bits
// HOLD    | complete word on out_data, ring frozen until taken
module r30_stream_reader
  import r30_stream_reader_pkg::*;
#(
  parameter int N   = R30_N_DEF,
  parameter int W   = R30_W_DEF,
  parameter int TAP = N / 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_valid,
  input  logic [N-1:0] seed_data,
  output logic         seed_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         seeded
);

  localparam int CW = $clog2(W + 1);

  r30_fsm_e        fsm_q;
  r30_fsm_e        fsm_d;
  logic [N-1:0]    state_q;
  logic [N-1:0]    ring_out;
  logic [N-1:0]    tap_only;
  logic [N-1:0]    seed_load;
  logic [CW-1:0]   count_q;
  logic            seed_fire;
  logic            step_en;
  logic            word_done;

  r30_stream_reader_ring #(.N(N)) u_ring (
    .state_in  (state_q),
    .state_out (ring_out)
  );

  // A new seed is always welcome; it simply aborts whatever word is in flight.
  assign seed_ready = 1'b1;
  assign seed_fire  = seed_valid && seed_ready;
  assign out_valid  = (fsm_q == ST_HOLD);
  assign seeded     = (fsm_q != ST_IDLE);

  // All-zero is a fixed point of Rule 30, so it is replaced by a single live cell at the tap.
  always_comb begin
    tap_only      = '0;
    tap_only[TAP] = 1'b1;
    seed_load     = (seed_data == '0) ? tap_only : seed_data;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) fsm_q <= ST_IDLE;
    else        fsm_q <= fsm_d;
  end

  // Next-state and datapath enables; a seed fire overrides every state.
  always_comb begin
    fsm_d     = fsm_q;
    step_en   = 1'b0;
    word_done = 1'b0;
    if (seed_fire) begin
      fsm_d = ST_FILL;
    end else begin
      case (fsm_q)
        ST_IDLE: fsm_d = ST_IDLE;
        ST_FILL: begin
          step_en = 1'b1;
          if (count_q == CW'(W - 1)) begin
            word_done = 1'b1;
            fsm_d     = ST_HOLD;
          end
        end
        ST_HOLD: if (out_ready) fsm_d = ST_FILL;
        default: fsm_d = ST_IDLE;
      endcase
    end
  end

  // Ring state, bit counter and word assembly; everything freezes outside FILL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= '0;
      out_data <= '0;
      count_q  <= '0;
    end else if (seed_fire) begin
      state_q <= seed_load;
      count_q <= '0;
    end else if (step_en) begin
      state_q <= ring_out;
      for (int i = 0; i < W; i++) begin
        if (count_q == CW'(i)) out_data[i] <= ring_out[TAP];
      end
      count_q <= word_done ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: doc/r30_stream_reader.md
R30_STREAM_READER -- requirements
Module: r30_stream_reader

Interface
REQ-001 Parameter N, default 128: width of the Rule 30 state ring.
REQ-002 Parameter W, default 32: bits per output word, 1..N.
REQ-003 Parameter TAP, default N/2: state index sampled as the output bit.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 seed_valid  in  1  seed offered.
REQ-008 seed_data  in  N  seed state.
REQ-009 seed_ready  out  1  seed accepted when seed_valid and seed_ready are both high.
REQ-010 out_valid  out  1  out_data holds a complete word.
REQ-011 out_data  out  W  harvested bits; bit 0 is the earliest.
REQ-012 out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
REQ-013 seeded  out  1  state register holds a valid seed.

Function
REQ-014 Step rule: next[i] = state[i-1] XOR (state[i] OR state[i+1]), with indices taken modulo N.
REQ-015 FSM states: IDLE (unseeded), FILL (stepping and collecting), HOLD (word presented).
REQ-016 seed_ready shall be 1 in every state after reset.
REQ-017 Seed fire loads the state register with seed_data, clears the bit counter, sets seeded=1 and enters FILL on the next cycle.
REQ-018 All-zero seed_data is a fixed point of the rule: the block shall load a state with only bit TAP set instead.
REQ-019 In each FILL cycle: state <= next(state); next(state)[TAP] is written into out_data[count]; count increments.
REQ-020 When count reaches W-1 in FILL, the block enters HOLD and out_valid rises on the next cycle.
REQ-021 Latency: the first word is valid exactly W cycles after the seed-fire cycle.
REQ-022 In HOLD the state register, out_data and count are frozen while out_ready=0; out_valid stays high and out_data stays stable.
REQ-023 Output fire in HOLD: out_valid drops and FILL resumes from the frozen state on the next cycle.
REQ-024 Seed fire in FILL or HOLD aborts the current word: out_valid goes to 0, count goes to 0, the new seed loads, and the block enters FILL.
REQ-025 Seed fire and output fire in the same cycle: the presented word counts as consumed, then the reseed applies.
REQ-026 In IDLE, out_valid=0 and no stepping occurs.
REQ-027 count is ceil(log2(W+1)) bits wide and resets to 0 at each word boundary.

Reset
REQ-028 On rst_n=0 at a clock edge: FSM goes to IDLE; out_valid=0, out_data=0, seeded=0, count=0, state register=0; seed_ready=1.
REQ-029 Reset mid-word discards all partial output with no out_valid pulse.
REQ-030 Reset has priority over a simultaneous seed fire.

Structure
REQ-031 A shared package shall hold the FSM state enumeration and the default N, W and TAP constants.
REQ-032 The next-state computation shall reuse the existing combinational Rule 30 ring array as its single sub-module (state_in to state_out).
REQ-033 No other sub-modules; target 120-400 lines of RTL.

Verification
REQ-034 Bench parameters: N=16, W=8, TAP=8. Seed 16'h0100, out_ready=1 -> out_valid rises 8 cycles after seed fire; out_data=8'h9D (center bits 1,0,1,1,1,0,0,1).
REQ-035 Seed 16'h0000 -> output identical to the 16'h0100 case (8'h9D).
REQ-036 Hold out_ready=0 for 20 cycles after out_valid rises -> out_data stays 8'h9D and the state does not advance; the next word equals the reference-model word 2.
REQ-037 Reseed at count=4 -> no out_valid for the aborted word; the next word matches a fresh run from the new seed.
REQ-038 Assert rst_n=0 in HOLD -> next cycle out_valid=0, seeded=0, out_data=0; no output until a new seed is accepted.
REQ-039 Run 10,000 random seeds with random out_ready backpressure against a software Rule 30 model -> every word matches and no word is lost or duplicated.
